// File: rtl/hazard_track.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_track
//  Description : Pipeline-side companion to the hazard unit of the 5-stage
//                core. It carries source/destination register addresses and
//                write controls from Decode through Execute, Memory and
//                Writeback. It produces the address-match and write-enable
//                signals the hazard unit consumes. It turns the hazard unit's
//                load-use stall and the branch-taken flush into Fetch/Decode/
//                Execute stall and flush controls. It also keeps saturating
//                stall and flush event counters.
//
//  Ports       : clk, reset        - rising-edge clock, async active-high reset
//                RA1D/RA2D/WA3D    - Decode source/destination addresses
//                RegWriteD         - Decode instruction writes the register file
//                MemtoRegD         - Decode instruction is a load
//                LDRstall          - load-use stall from the hazard unit
//                BranchTakenE      - branch resolved taken in Execute
//                cnt_clr           - synchronous clear of both counters
//                Match_*           - address comparisons for forwarding/stall
//                RegWriteE/M/W     - registered write enables per stage
//                MemtoRegE         - Execute instruction is a load
//                StallF/StallD/FlushD/FlushE - pipeline register controls
//                stall_cnt/flush_cnt - saturating event counters
//
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_track #(
    parameter int ADDR_W = 4,
    parameter int PC_REG = 15,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] RA1D,
    input  logic [ADDR_W-1:0] RA2D,
    input  logic [ADDR_W-1:0] WA3D,
    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic              LDRstall,
    input  logic              BranchTakenE,
    input  logic              cnt_clr,
    output logic              Match_1E_M,
    output logic              Match_1E_W,
    output logic              Match_2E_M,
    output logic              Match_2E_W,
    output logic              Match_12D_E,
    output logic              RegWriteE,
    output logic              RegWriteM,
    output logic              RegWriteW,
    output logic              MemtoRegE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [ADDR_W-1:0] c_pc_reg  = ADDR_W'(PC_REG);
    localparam logic [CNT_W-1:0]  c_cnt_max = {CNT_W{1'b1}};

    // Execute stage
    logic [ADDR_W-1:0] r_ra1_e;
    logic [ADDR_W-1:0] r_ra2_e;
    logic [ADDR_W-1:0] r_wa3_e;
    logic              r_regwrite_e;
    logic              r_memtoreg_e;
    // Memory stage
    logic [ADDR_W-1:0] r_wa3_m;
    logic              r_regwrite_m;
    logic              r_memtoreg_m;
    // Writeback stage
    logic [ADDR_W-1:0] r_wa3_w;
    logic              r_regwrite_w;
    // Counters
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_stall;
    logic w_flush_e;

    // A taken branch throws away the stalled instruction, so the branch
    // overrides the load-use stall for Fetch/Decode.
    assign w_stall   = LDRstall & ~BranchTakenE;
    assign w_flush_e = LDRstall | BranchTakenE;

    assign StallF = w_stall;
    assign StallD = w_stall;
    assign FlushD = BranchTakenE;
    assign FlushE = w_flush_e;

    // Execute register: loads Decode, or takes a bubble on flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ra1_e      <= '0;
            r_ra2_e      <= '0;
            r_wa3_e      <= '0;
            r_regwrite_e <= 1'b0;
            r_memtoreg_e <= 1'b0;
        end else if (w_flush_e) begin
            r_ra1_e      <= '0;
            r_ra2_e      <= '0;
            r_wa3_e      <= '0;
            r_regwrite_e <= 1'b0;
            r_memtoreg_e <= 1'b0;
        end else begin
            r_ra1_e      <= RA1D;
            r_ra2_e      <= RA2D;
            r_wa3_e      <= WA3D;
            r_regwrite_e <= RegWriteD;
            r_memtoreg_e <= MemtoRegD;
        end
    end

    // Memory and Writeback registers never stall or flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wa3_m      <= '0;
            r_regwrite_m <= 1'b0;
            r_memtoreg_m <= 1'b0;
            r_wa3_w      <= '0;
            r_regwrite_w <= 1'b0;
        end else begin
            r_wa3_m      <= r_wa3_e;
            r_regwrite_m <= r_regwrite_e;
            r_memtoreg_m <= r_memtoreg_e;
            r_wa3_w      <= r_wa3_m;
            r_regwrite_w <= r_regwrite_m;
        end
    end

    // Clear has priority over increment; increments stop at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (BranchTakenE && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    // Matches are not qualified with RegWrite; the hazard unit does that.
    // The PC register is never forwarded, so matches on it are suppressed.
    assign Match_1E_M  = (r_ra1_e == r_wa3_m) && (r_ra1_e != c_pc_reg);
    assign Match_1E_W  = (r_ra1_e == r_wa3_w) && (r_ra1_e != c_pc_reg);
    assign Match_2E_M  = (r_ra2_e == r_wa3_m) && (r_ra2_e != c_pc_reg);
    assign Match_2E_W  = (r_ra2_e == r_wa3_w) && (r_ra2_e != c_pc_reg);
    assign Match_12D_E = ((RA1D == r_wa3_e) && (RA1D != c_pc_reg)) ||
                         ((RA2D == r_wa3_e) && (RA2D != c_pc_reg));

    assign RegWriteE = r_regwrite_e;
    assign RegWriteM = r_regwrite_m;
    assign RegWriteW = r_regwrite_w;
    assign MemtoRegE = r_memtoreg_e;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    // Loads in Memory are tracked for completeness of the stage record but
    // nothing downstream of this block consumes it.
    logic w_unused;
    assign w_unused = r_memtoreg_m;

endmodule
`default_nettype wire

// File: tb/tb_hazard_track.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_track
//  Description : Self-checking bench for hazard_track. A queue of per-stage
//                instruction records and plain event counts form the
//                reference; outputs are compared every negative clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_track;

    localparam int ADDR_W = 4;
    localparam int PC_REG = 15;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] RA1D, RA2D, WA3D;
    logic              RegWriteD, MemtoRegD, LDRstall, BranchTakenE, cnt_clr;
    logic              Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
    logic              RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
    logic              StallF, StallD, FlushD, FlushE;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    hazard_track #(.ADDR_W(ADDR_W), .PC_REG(PC_REG), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
        .LDRstall(LDRstall), .BranchTakenE(BranchTakenE), .cnt_clr(cnt_clr),
        .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
        .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
        .Match_12D_E(Match_12D_E),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [ADDR_W-1:0] ra1;
        logic [ADDR_W-1:0] ra2;
        logic [ADDR_W-1:0] wa;
        logic              rw;
        logic              ml;
    } ins_t;

    ins_t hist[$];      // [0] = Execute, [1] = Memory, [2] = Writeback
    int   n_stall = 0;
    int   n_flush = 0;
    ins_t m_nx;

    function automatic bit mt(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst);
        return (src == dst) && (int'(src) != PC_REG);
    endfunction

    function automatic int sat(input int n);
        return (n > CNT_MAX) ? CNT_MAX : n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist = {};
            for (int i = 0; i < 3; i++) hist.push_back('0);
            n_stall = 0;
            n_flush = 0;
        end else begin
            if (LDRstall || BranchTakenE) m_nx = '0;
            else m_nx = '{RA1D, RA2D, WA3D, RegWriteD, MemtoRegD};
            hist.push_front(m_nx);
            void'(hist.pop_back());
            if (cnt_clr) begin
                n_stall = 0;
                n_flush = 0;
            end else begin
                if (LDRstall && !BranchTakenE) n_stall++;
                if (BranchTakenE) n_flush++;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (check_en && hist.size() == 3) begin
            chk("StallF", int'(StallF), int'(LDRstall && !BranchTakenE));
            chk("StallD", int'(StallD), int'(LDRstall && !BranchTakenE));
            chk("FlushD", int'(FlushD), int'(BranchTakenE));
            chk("FlushE", int'(FlushE), int'(LDRstall || BranchTakenE));
            chk("RegWriteE", int'(RegWriteE), int'(hist[0].rw));
            chk("RegWriteM", int'(RegWriteM), int'(hist[1].rw));
            chk("RegWriteW", int'(RegWriteW), int'(hist[2].rw));
            chk("MemtoRegE", int'(MemtoRegE), int'(hist[0].ml));
            chk("Match_1E_M", int'(Match_1E_M), int'(mt(hist[0].ra1, hist[1].wa)));
            chk("Match_1E_W", int'(Match_1E_W), int'(mt(hist[0].ra1, hist[2].wa)));
            chk("Match_2E_M", int'(Match_2E_M), int'(mt(hist[0].ra2, hist[1].wa)));
            chk("Match_2E_W", int'(Match_2E_W), int'(mt(hist[0].ra2, hist[2].wa)));
            chk("Match_12D_E", int'(Match_12D_E),
                int'(mt(RA1D, hist[0].wa) || mt(RA2D, hist[0].wa)));
            chk("stall_cnt", int'(stall_cnt), sat(n_stall));
            chk("flush_cnt", int'(flush_cnt), sat(n_flush));
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic bit hazard_now();
        return hist[0].ml && (mt(RA1D, hist[0].wa) || mt(RA2D, hist[0].wa));
    endfunction

    task automatic drive(input int ra1, input int ra2, input int wa,
                         input bit rw, input bit ml, input bit br, input bit clr);
        RA1D = ADDR_W'(ra1); RA2D = ADDR_W'(ra2); WA3D = ADDR_W'(wa);
        RegWriteD = rw; MemtoRegD = ml; BranchTakenE = br; cnt_clr = clr;
        LDRstall = hazard_now();
    endtask

    // Advance to the next posedge and settle just after it.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        RA1D = '0; RA2D = '0; WA3D = '0;
        RegWriteD = 0; MemtoRegD = 0; LDRstall = 0; BranchTakenE = 0; cnt_clr = 0;
        next_cycle();
        check_en = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("lit reset RegWriteE", int'(RegWriteE), 0);
        chk("lit reset RegWriteW", int'(RegWriteW), 0);
        chk("lit reset Match_1E_M", int'(Match_1E_M), 1);
        chk("lit reset stall_cnt", int'(stall_cnt), 0);
        next_cycle();
        reset = 1'b0;
        // Idle
        drive(0, 0, 0, 0, 0, 0, 0);
        next_cycle(); next_cycle();

        // Back-to-back ALU dependency on r3
        drive(0, 0, 3, 1, 0, 0, 0);
        next_cycle();
        drive(3, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lit alu Match_12D_E", int'(Match_12D_E), 1);
        next_cycle();
        drive(3, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lit alu Match_1E_M", int'(Match_1E_M), 1);
        chk("lit alu RegWriteM", int'(RegWriteM), 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lit alu Match_1E_W", int'(Match_1E_W), 1);
        chk("lit alu RegWriteW", int'(RegWriteW), 1);
        next_cycle(); next_cycle(); next_cycle();

        // Load-use on r5
        drive(0, 0, 5, 1, 1, 0, 0);
        next_cycle();
        drive(0, 5, 6, 1, 0, 0, 0);
        @(negedge clk);
        chk("lit ldr StallD", int'(StallD), 1);
        chk("lit ldr FlushE", int'(FlushE), 1);
        next_cycle();
        drive(0, 5, 6, 1, 0, 0, 0);
        @(negedge clk);
        chk("lit ldr StallD drop", int'(StallD), 0);
        chk("lit ldr stall_cnt", int'(stall_cnt), 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lit ldr Match_2E_W", int'(Match_2E_W), 1);
        next_cycle(); next_cycle(); next_cycle();

        // PC register suppression
        drive(0, 0, 15, 1, 0, 0, 0);
        next_cycle();
        drive(15, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lit pc Match_12D_E", int'(Match_12D_E), 0);
        next_cycle();
        drive(15, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lit pc Match_1E_M", int'(Match_1E_M), 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lit pc Match_1E_W", int'(Match_1E_W), 0);
        next_cycle();

        // Branch together with stall
        drive(1, 0, 2, 1, 0, 1, 0);
        LDRstall = 1'b1;
        @(negedge clk);
        chk("lit br StallD", int'(StallD), 0);
        chk("lit br FlushD", int'(FlushD), 1);
        chk("lit br FlushE", int'(FlushE), 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lit br RegWriteE", int'(RegWriteE), 0);
        chk("lit br flush_cnt", int'(flush_cnt), 1);
        chk("lit br stall_cnt", int'(stall_cnt), 1);
        next_cycle();

        // Saturation then clear
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            LDRstall = 1'b1;
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lit sat stall_cnt", int'(stall_cnt), 15);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 1);
        LDRstall = 1'b1;
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lit clr stall_cnt", int'(stall_cnt), 0);
        chk("lit clr flush_cnt", int'(flush_cnt), 0);
        next_cycle();

        // Randomized traffic with occasional mid-stream resets
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 40) == 0));
            if ($urandom_range(0, 3) == 0) LDRstall = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 100) == 0) reset = 1'b1;
            next_cycle();
            reset = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_track.md
# hazard_track

Pipeline-side companion to the hazard unit in the 5-stage core. It carries the register addresses and write controls of each instruction from Decode through Execute, Memory and Writeback. It produces the address-match and stage write-enable signals that the hazard unit consumes. It takes back the hazard unit's load-use stall, combines it with the branch-taken flush, and drives the stall/flush controls for the Fetch/Decode/Execute pipeline registers, along with saturating stall/flush event counters.

## Interface
Parameters:
- ADDR_W, 4: register address width.
- PC_REG, 15: register index never forwarded; matches on it are suppressed.
- CNT_W, 16: event counter width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high; one clock; polarity and synchronicity fixed.
- RA1D  in  ADDR_W  Decode source address 1.
- RA2D  in  ADDR_W  Decode source address 2.
- WA3D  in  ADDR_W  Decode destination address.
- RegWriteD  in  1  Decode instruction writes the register file.
- MemtoRegD  in  1  Decode instruction is a load.
- LDRstall  in  1  load-use stall from the hazard unit.
- BranchTakenE  in  1  branch resolved taken in Execute.
- cnt_clr  in  1  synchronous clear of both counters.
- Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W  out  1 each  Execute source address equals the Memory/Writeback destination.
- Match_12D_E  out  1  either Decode source equals the Execute destination.
- RegWriteE, RegWriteM, RegWriteW  out  1 each  registered write enables.
- MemtoRegE  out  1  Execute instruction is a load.
- StallF, StallD, FlushD, FlushE  out  1 each  pipeline register controls.
- stall_cnt, flush_cnt  out  CNT_W each  event counters.

## Operation
State registers:
- E stage: RA1E, RA2E, WA3E, RegWriteE, MemtoRegE.
- M stage: WA3M, RegWriteM, MemtoRegM.
- W stage: WA3W, RegWriteW.

Control outputs (combinational):
- StallF = StallD = LDRstall & ~BranchTakenE. A taken branch discards the stalled instruction, so no stall is needed.
- FlushD = BranchTakenE.
- FlushE = LDRstall | BranchTakenE.

E-stage update on each clock edge:
- If FlushE: bubble. RegWriteE=0, MemtoRegE=0, RA1E=RA2E=WA3E=0.
- Otherwise: load RA1D, RA2D, WA3D, RegWriteD, MemtoRegD.

M and W stages are unconditional shifts: E→M and M→W every cycle. They never stall or flush.

Match outputs (combinational from registered addresses):
- Match_aE_s = (RAaE == WA3s) & (RAaE != PC_REG), for a ∈ {1,2} and s ∈ {M,W}.
- Match_12D_E = ((RA1D==WA3E)&(RA1D!=PC_REG)) | ((RA2D==WA3E)&(RA2D!=PC_REG)).
- Matches are not gated with RegWrite; the hazard unit does that gating.

Counters:
- stall_cnt increments on every cycle with StallD=1.
- flush_cnt increments on every cycle with BranchTakenE=1.
- Both saturate at 2^CNT_W−1.
- cnt_clr wins over a simultaneous increment; the counter reads 0 next cycle.

Reset (asynchronous): all state registers and counters go to 0. Consequences:
- RegWrite*, MemtoRegE, stall_cnt and flush_cnt read 0.
- Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W read 1. All stored addresses are 0, and 0 != PC_REG. This is harmless because RegWrite*=0.
- Control outputs follow their inputs directly.

## Timing
- Latency: a Decode instruction appears in E one cycle later, M two cycles later, W three cycles later.
- Stall/flush controls and all Match outputs have zero-cycle combinational paths from inputs/registers. There are no register-to-output delays beyond the state registers.
- Load-use case: with a load in E and a dependent instruction in D:
  - Cycle n: Match_12D_E=1 and the hazard unit asserts LDRstall, so StallF=StallD=1 and FlushE=1.
  - Cycle n+1: the bubble sits in E; the dependent instruction is still in D, with MemtoRegE=0 so LDRstall drops.
  - Cycle n+2: the dependent instruction enters E with Match_xE_W=1 against the load.
- LDRstall and BranchTakenE both high: FlushD=1, FlushE=1, StallD=0. stall_cnt does not increment; flush_cnt does.
- Reset asserted mid-stream clears all stages immediately. The first edge after deassertion loads D as normal.

## Test plan
- Reset then idle: after reset, RegWriteE/M/W=0, stall_cnt=0, flush_cnt=0, Match_1E_M=1; with all D inputs 0, outputs stay stable.
- Back-to-back ALU dependency: D issues WA3D=3/RegWriteD=1, then next cycle RA1D=3 → Match_1E_M=1 one cycle later and Match_1E_W=1 the cycle after, with RegWriteM then RegWriteW asserted.
- Load-use: D issues MemtoRegD=1/WA3D=5, then RA2D=5 with LDRstall driven by the bench as Match_12D_E&MemtoRegE → exactly one cycle of StallD=1/FlushE=1, stall_cnt=1, then Match_2E_W=1.
- PC suppression: WA3D=15/RegWriteD=1 followed by RA1D=15 → Match_1E_M, Match_1E_W and Match_12D_E all stay 0.
- Branch flush with simultaneous stall: LDRstall=1 and BranchTakenE=1 in the same cycle → StallD=0, FlushD=1, FlushE=1, next RegWriteE=0, flush_cnt=1, stall_cnt unchanged.
- Counter saturation and clear: with CNT_W=4, hold LDRstall=1 for 20 cycles → stall_cnt=15; then assert cnt_clr together with LDRstall=1 → stall_cnt=0 next cycle.
